// File: rtl/relogio_pkg.sv
// Shared types, field limits and BCD helpers for the clock time-setting front end.
package relogio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_H,
    EDIT_M,
    EDIT_S,
    LOAD
  } state_t;

  typedef logic [3:0] bcd_t;

  // Limits are BCD-encoded so they compare directly against packed digit pairs
  localparam logic [7:0] HOURS_MAX  = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [5:0] MASK_H = 6'b110000;
  localparam logic [5:0] MASK_M = 6'b001100;
  localparam logic [5:0] MASK_S = 6'b000011;

  function automatic logic [7:0] bcd_inc(input logic [7:0] f, input logic [7:0] max);
    bcd_t msd;
    bcd_t lsd;
    msd = f[7:4];
    lsd = f[3:0];
    if (f == max)
      return '0;
    else if (lsd == 4'd9)
      return {msd + 4'd1, 4'd0};
    else
      return {msd, lsd + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_sanitize(input logic [7:0] f, input logic [7:0] max);
    if (f[7:4] > 4'd9 || f[3:0] > 4'd9 || f > max)
      return '0;
    else
      return f;
  endfunction

endpackage

// File: rtl/relogio_debounce.sv
// Key conditioning: 2-flop synchronizer, level debouncer and one-cycle press pulse.
module relogio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic main_clock,
  input  logic main_reset,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge main_clock) begin
    if (!main_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This sample completes the run of equal samples that accepts the new level
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/relogio_ajuste.sv
// Time-setting front end: field select/increment FSM, load handshake and blink mask.
module relogio_ajuste
  import relogio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_CYCLES    = 25000000
) (
  input  logic        main_clock,
  input  logic        main_reset,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load_valid,
  input  logic        load_ready,
  output logic        editing,
  output logic [5:0]  blank_mask
);

  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  state_t        state;
  state_t        state_next;
  logic          mode_p;
  logic          inc_p;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  relogio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .main_clock(main_clock),
    .main_reset(main_reset),
    .key_raw   (key_mode),
    .press     (mode_p)
  );

  relogio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .main_clock(main_clock),
    .main_reset(main_reset),
    .key_raw   (key_inc),
    .press     (inc_p)
  );

  always_ff @(posedge main_clock) begin
    if (!main_reset) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (mode_p) state_next = EDIT_H;
      EDIT_H:  if (mode_p) state_next = EDIT_M;
      EDIT_M:  if (mode_p) state_next = EDIT_S;
      EDIT_S:  if (mode_p) state_next = LOAD;
      LOAD:    if (load_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_valid = 1'b0;
    editing    = 1'b0;
    blank_mask = '0;
    unique case (state)
      EDIT_H: begin
        editing    = 1'b1;
        blank_mask = phase ? MASK_H : '0;
      end
      EDIT_M: begin
        editing    = 1'b1;
        blank_mask = phase ? MASK_M : '0;
      end
      EDIT_S: begin
        editing    = 1'b1;
        blank_mask = phase ? MASK_S : '0;
      end
      LOAD:    load_valid = 1'b1;
      default: ;
    endcase
  end

  // A mode pulse takes priority, so inc is only honoured when mode is quiet
  always_ff @(posedge main_clock) begin
    if (!main_reset) begin
      set_time <= '0;
    end else if (mode_p) begin
      if (state == IDLE)
        set_time <= {bcd_sanitize(cur_time[23:16], HOURS_MAX),
                     bcd_sanitize(cur_time[15:8],  MINSEC_MAX),
                     bcd_sanitize(cur_time[7:0],   MINSEC_MAX)};
    end else if (inc_p) begin
      unique case (state)
        EDIT_H:  set_time[23:16] <= bcd_inc(set_time[23:16], HOURS_MAX);
        EDIT_M:  set_time[15:8]  <= bcd_inc(set_time[15:8],  MINSEC_MAX);
        EDIT_S:  set_time[7:0]   <= bcd_inc(set_time[7:0],   MINSEC_MAX);
        default: ;
      endcase
    end
  end

  always_ff @(posedge main_clock) begin
    if (!main_reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (state_next != state) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: doc/relogio_ajuste.md
Name: relogio_ajuste

Overview:
- Time-setting front end for the six-digit 7-segment clock.
- Takes two raw KEY pushbuttons, debounces them, and runs a field-select/increment FSM over hours, minutes and seconds.
- Hands the edited BCD time to the clock core over a valid/ready load handshake.
- Drives a per-digit blink mask so the display shows which field is being edited.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a key level (20 ms at 50 MHz).
- BLINK_CYCLES, 25000000, cycles per blink phase of the edited field.

Ports:
- main_clock  in  1  system clock (CLOCK_50).
- main_reset  in  1  synchronous, active-low reset.
- key_mode  in  1  raw pushbutton, active-low, asynchronous to main_clock.
- key_inc  in  1  raw pushbutton, active-low, asynchronous to main_clock.
- cur_time  in  24  current clock time, packed BCD {h_msd,h_lsd,m_msd,m_lsd,s_msd,s_lsd}.
- set_time  out  24  edited time, same packing.
- load_valid  out  1  set_time ready to load into the clock core.
- load_ready  in  1  clock core accepts; transfer occurs on a cycle with load_valid&&load_ready.
- editing  out  1  high in EDIT_H/EDIT_M/EDIT_S.
- blank_mask  out  6  1 = blank digit; bit5=h_msd ... bit0=s_lsd.

Behaviour:
- One clock (main_clock); reset is synchronous and active-low (main_reset).
- Reset values:
  - state IDLE; set_time 0; load_valid 0; editing 0; blank_mask 0.
  - Debounced key levels 1 (released); all counters 0.
- Key path (per key):
  - 2-flop synchronizer feeds a debouncer.
  - The debouncer counter restarts whenever the synchronized sample differs from the accepted level.
  - The new level is accepted after DEBOUNCE_CYCLES equal samples.
  - A press is a one-cycle pulse on an accepted 1->0 transition.
  - If the key is first sampled low at edge N and held, the pulse is high in cycle N+2+DEBOUNCE_CYCLES.
  - The FSM reacts on the following edge.
- FSM:
  - IDLE --mode--> EDIT_H. On entry, cur_time is snapshotted into set_time.
  - EDIT_H --mode--> EDIT_M --mode--> EDIT_S --mode--> LOAD.
  - LOAD: load_valid=1, set_time held stable; on load_valid&&load_ready -> IDLE, with load_valid 0 next cycle.
- inc pulse in EDIT_x increments that field in BCD:
  - Hours: 23 -> 00. Minutes and seconds: 59 -> 00.
  - lsd 9 -> 0 with msd+1. Other fields are untouched.
- Ignored events:
  - inc in IDLE or LOAD is ignored.
  - mode in LOAD is ignored; it is not queued.
- Simultaneous mode and inc pulses in one cycle: mode wins, inc is dropped.
- Snapshot sanitising: any field with a digit >9 or a value above its limit (hours >23, min/sec >59) loads as 00.
- Blink:
  - The counter and phase restart (phase 0 = visible) on every state change.
  - Phase toggles every BLINK_CYCLES cycles.
  - The edited field's two mask bits equal the phase. All other bits are 0; mask is 0 in IDLE and LOAD.
- Reset mid-edit or mid-LOAD: edit is abandoned, no load_valid pulse, outputs return to reset values the next cycle.
- load_ready outside LOAD has no effect.

Decomposition:
- relogio_pkg:
  - state enum (IDLE, EDIT_H, EDIT_M, EDIT_S, LOAD).
  - bcd_t (4-bit digit).
  - Field limit constants HOURS_MAX=23, MINSEC_MAX=59.
  - Blink-mask constants per field.
- Sub-module relogio_debounce (synchronizer + debouncer + falling-edge pulse), instantiated for key_mode and key_inc.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
- Reset: main_reset=0 for 2 edges with keys released -> set_time=0, load_valid=0, editing=0, blank_mask=0.
- Edit entry and blink: cur_time=0x134507, press mode -> set_time=0x134507, editing=1, blank_mask=000000; after 8 cycles -> 110000; after 8 more -> 000000.
- BCD wrap:
  - Hours 09 + inc -> 10; hours 23 + inc -> 00 with minutes unchanged.
  - In EDIT_M, 59 + inc -> 00; in EDIT_S, 09 + inc -> 10.
- Handshake: advance to LOAD with set_time=0x000010, hold load_ready=0 for 5 cycles -> load_valid=1 and set_time constant; load_ready=1 -> next cycle IDLE, load_valid=0, editing=0.
- Debounce/priority:
  - key_inc low for 3 cycles then released -> no increment.
  - mode and inc pulses in the same cycle -> state advances, field unchanged.
- Sanitise and reset: cur_time=0x2A9965, press mode -> set_time=0x000000; assert main_reset mid-EDIT_M -> IDLE, load_valid never asserts.
